// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full-subtractor cell reused WIDTH times.
// Optional signed overflow flag enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, borrow_q, borrow_d;
    logic             d_bit, br_next, last, accept;

    assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign last    = cnt_q == CW'(WIDTH - 1);
    assign accept  = start && state_q != SHIFT;

    assign busy       = state_q == SHIFT;
    assign done       = state_q == DONE;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
        end
    end

    // Operands rotate so the final step still sees the original MSBs for the overflow term.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        if (accept) begin
            state_d = SHIFT;
            a_d     = a;
            b_d     = b;
            br_d    = 1'b0;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            a_d   = {a_q[0], a_q[WIDTH-1:1]};
            b_d   = {b_q[0], b_q[WIDTH-1:1]};
            r_d   = {d_bit, r_q[WIDTH-1:1]};
            br_d  = br_next;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                state_d  = DONE;
                diff_d   = {d_bit, r_q[WIDTH-1:1]};
                borrow_d = br_next;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (!accept && state_q == SHIFT && last)
            ovf_q <= (a_q[0] ^ b_q[0]) & (a_q[0] ^ d_bit);
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif
endmodule
